cu: RTL and testbench
=====================

CU -- requirements
Module: cu

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 go  in  1  start request, sampled in sIDLE.
REQ-004 F  in  3  function select, sampled in sLOAD: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 DIV, 101 MUL, 110/111 PASS.
REQ-005 done_calc, done_div, done_mult  in  1 each  completion strobes from calc unit, divider and multiplier.
REQ-006 div_by_zero  in  1  divider zero-divisor indication.
REQ-007 en_f, en_x, en_y  out  1 each  load enables for the F, X and Y registers.
REQ-008 go_calc  out  1  start calc unit; op_calc  out  2  calc op (00 add, 01 sub, 10 and, 11 xor).
REQ-009 go_div, go_mult  out  1 each  start divider or multiplier.
REQ-010 sel_h  out  1  high-output mux select; sel_l  out  2  low-output mux select.
REQ-011 en_out_h, en_out_l  out  1 each  output register load enables.
REQ-012 done  out  1  operation complete; errorFlag  out  1  divide-by-zero error.
REQ-013 CS  out  4  current state code.

Function
REQ-014 Moore FSM; all outputs decode combinationally from CS, except errorFlag, which is a registered bit.
REQ-015 State codes: sIDLE 0, sLOAD 1, sADD 2, sSUB 3, sAND 4, sXOR 5, sDIV 6, sMUL 7, sPASS 8, sDONE_CALC 9, sDONE_DIV 10, sDONE_MUL 11, sOUT_CALC 12, sOUT_D_M 13; codes 14-15 go to sIDLE on the next edge.
REQ-016 Control word {en_f,en_x,en_y,go_calc,op_calc,go_div,go_mult,sel_h,sel_l,en_out_h,en_out_l}; every bit not listed for a state is 0.
REQ-017 sIDLE: all 0. sLOAD: en_f=en_x=en_y=1.
REQ-018 sADD/sSUB/sAND/sXOR: go_calc=1, op_calc=00/01/10/11 respectively.
REQ-019 sDIV: go_div=1. sMUL: go_mult=1. sPASS: en_out_l=1.
REQ-020 sDONE_CALC: sel_l=01. sDONE_DIV: sel_h=1, sel_l=11. sDONE_MUL: sel_l=10.
REQ-021 sOUT_CALC: en_out_l=1. sOUT_D_M: op_calc=01, en_out_h=1, en_out_l=1.
REQ-022 done=1 only in sOUT_CALC, sOUT_D_M and sPASS.
REQ-023 sIDLE goes to sLOAD when go=1, otherwise stays in sIDLE.
REQ-024 sLOAD branches on F to the matching operation state on the next edge.
REQ-025 Exception to REQ-024: sLOAD with F=100 and div_by_zero=1 goes directly to sOUT_D_M and sets errorFlag.
REQ-026 sADD..sXOR stay until done_calc=1, then go to sDONE_CALC.
REQ-027 sDIV goes to sOUT_D_M and sets errorFlag if div_by_zero=1; otherwise it goes to sDONE_DIV when done_div=1, else it stays.
REQ-028 sMUL stays until done_mult=1, then goes to sDONE_MUL.
REQ-029 sPASS goes to sIDLE.
REQ-030 sDONE_CALC goes to sOUT_CALC. sDONE_DIV and sDONE_MUL go to sOUT_D_M.
REQ-031 sOUT_CALC and sOUT_D_M go to sIDLE unconditionally.
REQ-032 errorFlag is cleared on entry to sLOAD; otherwise it holds, so it stays visible in sIDLE after an error.
REQ-033 go is ignored in every state except sIDLE.
REQ-034 Done strobes and div_by_zero are ignored in states that do not test them.
REQ-035 If several done strobes are asserted together, only the one relevant to the current state is used.

Reset
REQ-036 rst=0 asynchronously forces CS=sIDLE and errorFlag=0, so every output is 0.
REQ-037 Asserting reset mid-operation aborts the operation; after rst returns to 1, the block waits in sIDLE for go.

Verification
REQ-038 Reset then go=0 -> CS=0, control word all 0, done=0.
REQ-039 ADD path: go=1 for one edge, then F=000 -> CS 1 (LOAD word 1_1_1_0_00_0_0_0_00_0_0), then CS 2 (go_calc=1, op 00).
REQ-040 ADD path, continued: done_calc=1 -> CS 9 (sel_l=01), then CS 12 (en_out_l=1, done=1), then CS 0.
REQ-041 Divide by zero: F=100 and div_by_zero=1 in sLOAD -> next edge CS=13 with word 0_0_0_0_01_0_0_0_00_1_1, done=1, errorFlag=1; next edge CS=0.
REQ-042 Normal DIV: F=100, div_by_zero=0 -> CS 6, then done_div=1 -> CS 10 (sel_h=1, sel_l=11), then CS 13, then CS 0, errorFlag=0.
REQ-043 MUL: F=101 -> CS 7, then done_mult=1 -> CS 11 (sel_l=10), then CS 13.
REQ-044 PASS: F=110 -> CS 8 (en_out_l=1, done=1), then CS 0.
REQ-045 Reset mid-op: rst=0 while in sADD -> CS=0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/cu.sv
// rtl/cu.sv - Moore control unit sequencing load, ALU/divide/multiply and output stages.
// errorFlag is the only registered output; everything else decodes from the state register.
module cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [2:0] F,
    input  logic       done_calc,
    input  logic       done_div,
    input  logic       done_mult,
    input  logic       div_by_zero,
    output logic       en_f,
    output logic       en_x,
    output logic       en_y,
    output logic       go_calc,
    output logic [1:0] op_calc,
    output logic       go_div,
    output logic       go_mult,
    output logic       sel_h,
    output logic [1:0] sel_l,
    output logic       en_out_h,
    output logic       en_out_l,
    output logic       done,
    output logic       errorFlag,
    output logic [3:0] CS
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_ADD       = 4'd2,
        S_SUB       = 4'd3,
        S_AND       = 4'd4,
        S_XOR       = 4'd5,
        S_DIV       = 4'd6,
        S_MUL       = 4'd7,
        S_PASS      = 4'd8,
        S_DONE_CALC = 4'd9,
        S_DONE_DIV  = 4'd10,
        S_DONE_MUL  = 4'd11,
        S_OUT_CALC  = 4'd12,
        S_OUT_D_M   = 4'd13
    } state_t;

    state_t cs_q, cs_d;
    logic   err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q  <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            cs_q  <= cs_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        cs_d  = cs_q;
        err_d = err_q;
        case (cs_q)
            S_IDLE: begin
                if (go) begin
                    cs_d  = S_LOAD;
                    err_d = 1'b0;
                end
            end
            S_LOAD: begin
                case (F)
                    3'b000: cs_d = S_ADD;
                    3'b001: cs_d = S_SUB;
                    3'b010: cs_d = S_AND;
                    3'b011: cs_d = S_XOR;
                    3'b100: begin
                        // A known-zero divisor skips the divider entirely.
                        if (div_by_zero) begin
                            cs_d  = S_OUT_D_M;
                            err_d = 1'b1;
                        end else begin
                            cs_d = S_DIV;
                        end
                    end
                    3'b101:  cs_d = S_MUL;
                    default: cs_d = S_PASS;
                endcase
            end
            S_ADD, S_SUB, S_AND, S_XOR: begin
                if (done_calc) cs_d = S_DONE_CALC;
            end
            S_DIV: begin
                if (div_by_zero) begin
                    cs_d  = S_OUT_D_M;
                    err_d = 1'b1;
                end else if (done_div) begin
                    cs_d = S_DONE_DIV;
                end
            end
            S_MUL: begin
                if (done_mult) cs_d = S_DONE_MUL;
            end
            S_DONE_CALC:           cs_d = S_OUT_CALC;
            S_DONE_DIV, S_DONE_MUL: cs_d = S_OUT_D_M;
            default:               cs_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_f     = 1'b0;
        en_x     = 1'b0;
        en_y     = 1'b0;
        go_calc  = 1'b0;
        op_calc  = 2'b00;
        go_div   = 1'b0;
        go_mult  = 1'b0;
        sel_h    = 1'b0;
        sel_l    = 2'b00;
        en_out_h = 1'b0;
        en_out_l = 1'b0;
        done     = 1'b0;
        case (cs_q)
            S_LOAD: begin
                en_f = 1'b1;
                en_x = 1'b1;
                en_y = 1'b1;
            end
            S_ADD: go_calc = 1'b1;
            S_SUB: begin
                go_calc = 1'b1;
                op_calc = 2'b01;
            end
            S_AND: begin
                go_calc = 1'b1;
                op_calc = 2'b10;
            end
            S_XOR: begin
                go_calc = 1'b1;
                op_calc = 2'b11;
            end
            S_DIV: go_div  = 1'b1;
            S_MUL: go_mult = 1'b1;
            S_PASS: begin
                en_out_l = 1'b1;
                done     = 1'b1;
            end
            S_DONE_CALC: sel_l = 2'b01;
            S_DONE_DIV: begin
                sel_h = 1'b1;
                sel_l = 2'b11;
            end
            S_DONE_MUL: sel_l = 2'b10;
            S_OUT_CALC: begin
                en_out_l = 1'b1;
                done     = 1'b1;
            end
            S_OUT_D_M: begin
                op_calc  = 2'b01;
                en_out_h = 1'b1;
                en_out_l = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign errorFlag = err_q;
    assign CS        = cs_q;

endmodule

// File: tb/tb_cu.sv
// tb/tb_cu.sv - directed self-checking bench for the cu control unit.
module tb_cu;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [2:0] F;
    logic       done_calc, done_div, done_mult, div_by_zero;
    logic       en_f, en_x, en_y, go_calc, go_div, go_mult, sel_h;
    logic [1:0] op_calc, sel_l;
    logic       en_out_h, en_out_l, done, errorFlag;
    logic [3:0] CS;

    int vectors = 0;
    int errors  = 0;

    cu dut (
        .clk(clk), .rst(rst), .go(go), .F(F),
        .done_calc(done_calc), .done_div(done_div), .done_mult(done_mult),
        .div_by_zero(div_by_zero),
        .en_f(en_f), .en_x(en_x), .en_y(en_y), .go_calc(go_calc), .op_calc(op_calc),
        .go_div(go_div), .go_mult(go_mult), .sel_h(sel_h), .sel_l(sel_l),
        .en_out_h(en_out_h), .en_out_l(en_out_l), .done(done),
        .errorFlag(errorFlag), .CS(CS)
    );

    always #5 clk = ~clk;

    // Control word order: en_f,en_x,en_y,go_calc,op_calc[1:0],go_div,go_mult,sel_h,sel_l[1:0],en_out_h,en_out_l
    localparam logic [12:0] W_ZERO  = 13'b0_0_0_0_00_0_0_0_00_0_0;
    localparam logic [12:0] W_LOAD  = 13'b1_1_1_0_00_0_0_0_00_0_0;
    localparam logic [12:0] W_ADD   = 13'b0_0_0_1_00_0_0_0_00_0_0;
    localparam logic [12:0] W_DCALC = 13'b0_0_0_0_00_0_0_0_01_0_0;
    localparam logic [12:0] W_OCALC = 13'b0_0_0_0_00_0_0_0_00_0_1;
    localparam logic [12:0] W_ODM   = 13'b0_0_0_0_01_0_0_0_00_1_1;
    localparam logic [12:0] W_DIV   = 13'b0_0_0_0_00_1_0_0_00_0_0;
    localparam logic [12:0] W_DDIV  = 13'b0_0_0_0_00_0_0_1_11_0_0;
    localparam logic [12:0] W_MUL   = 13'b0_0_0_0_00_0_1_0_00_0_0;
    localparam logic [12:0] W_DMUL  = 13'b0_0_0_0_00_0_0_0_10_0_0;

    function automatic logic [12:0] word();
        return {en_f, en_x, en_y, go_calc, op_calc, go_div, go_mult, sel_h, sel_l, en_out_h, en_out_l};
    endfunction

    task automatic check(input string tag, input logic [3:0] exp_cs, input logic [12:0] exp_w,
                         input logic exp_done, input logic exp_err);
        logic [19:0] obs, exp;
        obs = {CS, word(), done, errorFlag, 1'b0};
        exp = {exp_cs, exp_w, exp_done, exp_err, 1'b0};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed CS=%0d word=%b done=%b err=%b, expected CS=%0d word=%b done=%b err=%b",
                   tag, CS, word(), done, errorFlag, exp_cs, exp_w, exp_done, exp_err);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; F = 3'b000;
        done_calc = 1'b0; done_div = 1'b0; done_mult = 1'b0; div_by_zero = 1'b0;
        #12;
        check("reset", 4'd0, W_ZERO, 1'b0, 1'b0);
        step(); rst = 1'b1;
        step();
        check("idle_go0", 4'd0, W_ZERO, 1'b0, 1'b0);

        // ADD, with the other done strobes asserted to show they are ignored
        go = 1'b1; F = 3'b000;
        step(); check("add_load", 4'd1, W_LOAD, 1'b0, 1'b0);
        step(); check("add_op", 4'd2, W_ADD, 1'b0, 1'b0);
        done_div = 1'b1; done_mult = 1'b1; div_by_zero = 1'b1;
        step(); check("add_wait", 4'd2, W_ADD, 1'b0, 1'b0);
        done_div = 1'b0; done_mult = 1'b0; div_by_zero = 1'b0; go = 1'b0;
        done_calc = 1'b1;
        step(); check("add_donecalc", 4'd9, W_DCALC, 1'b0, 1'b0);
        done_calc = 1'b0;
        step(); check("add_out", 4'd12, W_OCALC, 1'b1, 1'b0);
        step(); check("add_idle", 4'd0, W_ZERO, 1'b0, 1'b0);

        // SUB, AND, XOR
        for (int op = 1; op < 4; op++) begin
            go = 1'b1; F = 3'(op);
            step(); check("calc_load", 4'd1, W_LOAD, 1'b0, 1'b0);
            go = 1'b0;
            step(); check("calc_op", 4'(2 + op), {3'b000, 1'b1, 2'(op), 7'b0}, 1'b0, 1'b0);
            done_calc = 1'b1;
            step(); check("calc_done", 4'd9, W_DCALC, 1'b0, 1'b0);
            done_calc = 1'b0;
            step(); step();
            check("calc_idle", 4'd0, W_ZERO, 1'b0, 1'b0);
        end

        // Divide by zero caught in LOAD
        go = 1'b1; F = 3'b100; div_by_zero = 1'b1;
        step(); check("dbz_load", 4'd1, W_LOAD, 1'b0, 1'b0);
        go = 1'b0;
        step(); check("dbz_out", 4'd13, W_ODM, 1'b1, 1'b1);
        step(); check("dbz_idle", 4'd0, W_ZERO, 1'b0, 1'b1);
        div_by_zero = 1'b0;
        step(); check("dbz_hold", 4'd0, W_ZERO, 1'b0, 1'b1);

        // Normal DIV; errorFlag clears on entry to LOAD
        go = 1'b1;
        step(); check("div_load", 4'd1, W_LOAD, 1'b0, 1'b0);
        go = 1'b0;
        step(); check("div_op", 4'd6, W_DIV, 1'b0, 1'b0);
        step(); check("div_wait", 4'd6, W_DIV, 1'b0, 1'b0);
        done_div = 1'b1;
        step(); check("div_done", 4'd10, W_DDIV, 1'b0, 1'b0);
        done_div = 1'b0;
        step(); check("div_out", 4'd13, W_ODM, 1'b1, 1'b0);
        step(); check("div_idle", 4'd0, W_ZERO, 1'b0, 1'b0);

        // Divide by zero raised while in DIV
        go = 1'b1;
        step(); go = 1'b0;
        step(); check("div2_op", 4'd6, W_DIV, 1'b0, 1'b0);
        div_by_zero = 1'b1;
        step(); check("div2_err", 4'd13, W_ODM, 1'b1, 1'b1);
        div_by_zero = 1'b0;
        step(); check("div2_idle", 4'd0, W_ZERO, 1'b0, 1'b1);

        // MUL
        go = 1'b1; F = 3'b101;
        step(); check("mul_load", 4'd1, W_LOAD, 1'b0, 1'b0);
        go = 1'b0;
        step(); check("mul_op", 4'd7, W_MUL, 1'b0, 1'b0);
        done_calc = 1'b1;
        step(); check("mul_wait", 4'd7, W_MUL, 1'b0, 1'b0);
        done_calc = 1'b0; done_mult = 1'b1;
        step(); check("mul_done", 4'd11, W_DMUL, 1'b0, 1'b0);
        done_mult = 1'b0;
        step(); check("mul_out", 4'd13, W_ODM, 1'b1, 1'b0);
        step(); check("mul_idle", 4'd0, W_ZERO, 1'b0, 1'b0);

        // PASS for both 110 and 111
        for (int p = 6; p < 8; p++) begin
            go = 1'b1; F = 3'(p);
            step(); go = 1'b0;
            step(); check("pass", 4'd8, W_OCALC, 1'b1, 1'b0);
            step(); check("pass_idle", 4'd0, W_ZERO, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-operation
        go = 1'b1; F = 3'b000;
        step(); step();
        check("rst_pre", 4'd2, W_ADD, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check("rst_async", 4'd0, W_ZERO, 1'b0, 1'b0);
        go = 1'b0;
        step(); rst = 1'b1;
        step(); step();
        check("rst_wait", 4'd0, W_ZERO, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
